// File: rtl/if_prefetch_queue_if.sv
// Signal bundle between the prefetch queue, the instruction memory port and
// the decode stage. The master side is the prefetch queue itself.
interface if_prefetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output instr_valid_o,
        output instr_o,
        output pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  instr_valid_o,
        input  instr_o,
        input  pc_o,
        output instr_ready_i
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps at most one memory
// request outstanding and buffers fetched {pc, instr} pairs for decode.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    if_prefetch_queue_if.master    bus,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

    logic [31:0]   fpc;
    logic [31:0]   pend_pc;
    logic          pend;
    logic          drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          resp;
    logic          req;
    logic          grant;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [PW+1:0] reserved;

    // The outstanding response already owns a slot, so a push can never
    // land on a full queue; a pop in the same cycle is deliberately not credited.
    always_comb begin
        reserved   = {1'b0, count} + {{(PW+1){1'b0}}, pend};
        resp       = pend & bus.imem_rvalid_i;
        req        = rst_i & start_i & ~redirect_i
                   & (~pend | bus.imem_rvalid_i) & (reserved < DEPTH_W);
        grant      = req & bus.imem_gnt_i;
        head_valid = (count != '0);
        pop        = head_valid & bus.instr_ready_i;
        push       = resp & ~drop & ~redirect_i;
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = fpc;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = head_valid ? instr_mem[rd_ptr] : 32'h0;
    assign bus.pc_o          = head_valid ? pc_mem[rd_ptr] : 32'h0;
    assign count_o           = count;

    // Redirect wins over fetch and push; a response still in flight at that
    // moment is marked for discard so stale code never enters the queue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fpc     <= RESET_PC;
            pend_pc <= 32'h0;
            pend    <= 1'b0;
            drop    <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else if (redirect_i) begin
            fpc    <= redirect_pc_i & ~32'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pend   <= pend & ~bus.imem_rvalid_i;
            drop   <= pend & ~bus.imem_rvalid_i;
        end else begin
            if (grant) begin
                pend    <= 1'b1;
                pend_pc <= fpc;
                fpc     <= fpc + 32'd4;
            end else if (resp) begin
                pend <= 1'b0;
            end
            if (resp && drop) begin
                drop <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pend_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a queue-based model of the fetch/queue rules
// plus a simple memory responder, directed scenarios and a random phase.
module tb_if_prefetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   start_i;
    logic                   redirect_i;
    logic [31:0]            redirect_pc_i;
    logic [$clog2(DEPTH):0] count_o;

    if_prefetch_queue_if bus();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .bus           (bus),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    int          vectors;
    int          miscompares;
    entry_t      mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_pend_pc;
    logic        m_pend;
    logic        m_stale;
    logic        env_busy;
    int          env_wait;
    logic [31:0] env_addr;
    logic        spur_en;
    logic        st_level;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput(input logic exp_req);
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        exp_pc  = (mq.size() > 0) ? mq[0].pc  : 32'h0;
        exp_ins = (mq.size() > 0) ? mq[0].ins : 32'h0;
        compare("imem_req",    32'(bus.imem_req_o),    32'(exp_req));
        compare("imem_addr",   bus.imem_addr_o,        m_fpc);
        compare("instr_valid", 32'(bus.instr_valid_o), 32'(mq.size() > 0));
        compare("instr",       bus.instr_o,            exp_ins);
        compare("pc",          bus.pc_o,               exp_pc);
        compare("count",       32'(count_o),           32'(mq.size()));
    endtask

    // One clock of stimulus: drive inputs, check, then advance model and memory.
    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                 input logic rdy, input logic g, input int lat);
        logic env_rv;
        logic resp;
        logic grant;
        logic exp_req;
        env_rv            = env_busy && (env_wait == 0);
        start_i           = st;
        redirect_i        = rd;
        redirect_pc_i     = rpc;
        bus.instr_ready_i = rdy;
        bus.imem_rvalid_i = env_rv || (spur_en && !env_busy && ($urandom_range(0, 7) == 0));
        bus.imem_rdata_i  = env_rv ? memfn(env_addr) : $urandom;
        bus.imem_gnt_i    = g && (!env_busy || env_rv);
        resp    = bus.imem_rvalid_i && m_pend;
        exp_req = st && !rd && (!m_pend || resp) && ((mq.size() + int'(m_pend)) < DEPTH);
        #1;
        checkOutput(exp_req);
        grant = exp_req && bus.imem_gnt_i;
        if ((mq.size() > 0) && rdy) void'(mq.pop_front());
        if (rd) begin
            mq.delete();
            m_fpc   = {rpc[31:2], 2'b00};
            m_stale = m_pend && !resp;
            m_pend  = m_pend && !resp;
        end else begin
            if (resp) begin
                if (m_stale) m_stale = 1'b0;
                else mq.push_back('{pc: m_pend_pc, ins: bus.imem_rdata_i});
                m_pend = 1'b0;
            end
            if (grant) begin
                m_pend    = 1'b1;
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
        if (env_rv) env_busy = 1'b0;
        if (grant) begin
            env_busy = 1'b1;
            env_addr = m_pend_pc;
            env_wait = lat;
        end else if (env_busy && env_wait > 0) begin
            env_wait--;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic applyReset();
        start_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        mq.delete();
        m_fpc   = RPC;
        m_pend  = 1'b0;
        m_stale = 1'b0;
        compare("rst_req",   32'(bus.imem_req_o),    32'h0);
        compare("rst_addr",  bus.imem_addr_o,        32'h100);
        compare("rst_valid", 32'(bus.instr_valid_o), 32'h0);
        compare("rst_instr", bus.instr_o,            32'h0);
        compare("rst_pc",    bus.pc_o,               32'h0);
        compare("rst_count", 32'(count_o),           32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic s(input logic rdy, input logic g, input int lat);
        applyStimulus(1'b1, 1'b0, 32'h0, rdy, g, lat);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        m_fpc = RPC; m_pend = 1'b0; m_stale = 1'b0; m_pend_pc = 32'h0;
        env_busy = 1'b0; env_wait = 0; env_addr = 32'h0; spur_en = 1'b0;
        repeat (2) @(negedge clk_i);
        applyReset();

        // Zero-wait streaming with ready high.
        s(1, 1, 0);
        compare("t1_addr1", bus.imem_addr_o, 32'h104);
        compare("t1_noval", 32'(bus.instr_valid_o), 32'h0);
        s(1, 1, 0);
        compare("t1_val", 32'(bus.instr_valid_o), 32'h1);
        compare("t1_pc", bus.pc_o, 32'h100);
        compare("t1_ins", bus.instr_o, memfn(32'h100));
        compare("t1_addr2", bus.imem_addr_o, 32'h108);
        s(1, 1, 0); s(1, 1, 0);
        compare("t1_pc3", bus.pc_o, 32'h108);
        compare("t1_cnt", 32'(count_o), 32'h1);
        compare("t1_addr4", bus.imem_addr_o, 32'h110);

        // Ready low until the queue fills, then a single pop.
        repeat (5) s(0, 1, 0);
        compare("t2_full", 32'(count_o), 32'h4);
        compare("t2_noreq", 32'(bus.imem_req_o), 32'h0);
        compare("t2_addr", bus.imem_addr_o, 32'h118);
        compare("t2_pc", bus.pc_o, 32'h108);
        s(1, 1, 0);
        compare("t2_cnt3", 32'(count_o), 32'h3);
        compare("t2_req", 32'(bus.imem_req_o), 32'h1);
        compare("t2_addr2", bus.imem_addr_o, 32'h118);
        s(0, 1, 0);
        compare("t2_oneshot", 32'(bus.imem_req_o), 32'h0);
        compare("t2_addr3", bus.imem_addr_o, 32'h11C);

        // Grant withheld for three cycles.
        s(1, 0, 0);
        compare("t3_req", 32'(bus.imem_req_o), 32'h1);
        compare("t3_cnt", 32'(count_o), 32'h3);
        for (int i = 0; i < 3; i++) begin
            s(0, 0, 0);
            compare("t3_hold_req", 32'(bus.imem_req_o), 32'h1);
            compare("t3_hold_addr", bus.imem_addr_o, 32'h11C);
        end
        s(0, 1, 2);
        compare("t3_adv", bus.imem_addr_o, 32'h120);
        compare("t3_req_lo", 32'(bus.imem_req_o), 32'h0);

        // Redirect with 3 queued entries and a response outstanding.
        applyStimulus(1'b1, 1'b1, 32'h203, 1'b0, 1'b1, 0);
        compare("t4_cnt", 32'(count_o), 32'h0);
        compare("t4_addr", bus.imem_addr_o, 32'h200);
        s(1, 1, 0);
        compare("t4_wait_req", 32'(bus.imem_req_o), 32'h0);
        s(1, 1, 0);
        compare("t4_dropped", 32'(count_o), 32'h0);
        compare("t4_addr2", bus.imem_addr_o, 32'h204);
        s(1, 1, 0);
        compare("t4_pc", bus.pc_o, 32'h200);
        compare("t4_ins", bus.instr_o, memfn(32'h200));

        // Redirect coinciding with rvalid and a pop.
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 0);
        compare("t5_cnt", 32'(count_o), 32'h0);
        compare("t5_addr", bus.imem_addr_o, 32'h300);
        s(1, 1, 0);
        compare("t5_addr2", bus.imem_addr_o, 32'h304);
        s(1, 1, 2);
        compare("t5_pc", bus.pc_o, 32'h300);
        compare("t5_cnt1", 32'(count_o), 32'h1);

        // Reset while a response is outstanding; the late response is ignored.
        applyReset();
        s(1, 1, 0);
        compare("t6_req", 32'(bus.imem_req_o), 32'h1);
        compare("t6_addr", bus.imem_addr_o, 32'h100);
        s(1, 1, 0);
        s(1, 1, 0);
        compare("t6_late", 32'(count_o), 32'h0);
        compare("t6_addr2", bus.imem_addr_o, 32'h104);
        s(1, 1, 0);
        compare("t6_pc", bus.pc_o, 32'h100);
        compare("t6_cnt", 32'(count_o), 32'h1);

        // Random phase.
        spur_en  = 1'b1;
        st_level = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) applyReset();
            if ($urandom_range(0, 63) == 0) st_level = ~st_level;
            applyStimulus(st_level, ($urandom_range(0, 31) == 0), $urandom,
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
